// File: rtl/enc8_3_seq_if.sv
// Bus between the event encoder and its consumer. The slave side is the encoder;
// the master side drives the event lines and the ready/acknowledge path.
interface enc8_3_seq_if;
  logic       ena;
  logic [7:0] d;
  logic       ready;
  logic       ovf_clr;
  logic [2:0] a;
  logic       valid;
  logic [7:0] pend;
  logic       ovf;
  logic       state_dbg;

  modport slave (
    input  ena, d, ready, ovf_clr,
    output a, valid, pend, ovf, state_dbg
  );

  modport master (
    output ena, d, ready, ovf_clr,
    input  a, valid, pend, ovf, state_dbg
  );
endinterface

// File: rtl/enc8_3_seq.sv
// Sequential 8-to-3 priority encoder: captures event lines into a pending register
// and offers one pending index at a time, clearing each bit as it is accepted.
module enc8_3_seq #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  enc8_3_seq_if.slave   bus
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // While valid is 1 and ready is 0, a is held stable. ready is ignored when valid is 0.

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_a;
  logic       r_valid;
  logic [7:0] r_pend;
  logic       r_ovf;

  state_t     w_nxt_state;
  logic [2:0] w_nxt_a;
  logic       w_nxt_valid;
  logic [7:0] w_clr_mask;
  logic [7:0] w_set;
  logic [7:0] w_pend_next;
  logic [2:0] w_sel;
  logic       w_ovf_set;

  assign w_clr_mask  = (r_valid && bus.ready) ? (8'b1 << r_a) : 8'b0;
  assign w_set       = bus.ena ? bus.d : 8'b0;
  // Set is OR-ed after the clear so a re-asserted accepted bit stays pending.
  assign w_pend_next = (r_pend & ~w_clr_mask) | w_set;
  assign w_ovf_set   = |(w_set & r_pend & ~w_clr_mask);

  // Last match in scan order wins, so the scan direction picks the priority.
  always_comb begin
    w_sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (HIGH_FIRST) begin
        if (w_pend_next[i]) w_sel = 3'(i);
      end else begin
        if (w_pend_next[7-i]) w_sel = 3'(7 - i);
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_a     = r_a;
    w_nxt_valid = r_valid;
    case (r_state)
      IDLE: begin
        if (|w_pend_next) begin
          w_nxt_a     = w_sel;
          w_nxt_valid = 1'b1;
          w_nxt_state = OFFER;
        end
      end
      OFFER: begin
        if (bus.ready) begin
          if (|w_pend_next) begin
            w_nxt_a = w_sel;
          end else begin
            w_nxt_valid = 1'b0;
            w_nxt_state = IDLE;
          end
        end
      end
      default: begin
        w_nxt_valid = 1'b0;
        w_nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= 3'd0;
      r_valid <= 1'b0;
      r_pend  <= 8'd0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_a     <= w_nxt_a;
      r_valid <= w_nxt_valid;
      r_pend  <= w_pend_next;
      r_ovf   <= w_ovf_set | (r_ovf & ~bus.ovf_clr);
    end
  end

  assign bus.a         = r_a;
  assign bus.valid     = r_valid;
  assign bus.pend      = r_pend;
  assign bus.ovf       = r_ovf;
  assign bus.state_dbg = r_state;

endmodule
